// File: rtl/store_buffer_dual_if.sv
// Pipeline/memory-side bundle of the dual-lane store buffer: M-stage stores and loads,
// forwarded load data, the single memory write port and status flags.
interface store_buffer_dual_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    logic                     memwritem_odd;
    logic [AW-1:0]            aluoutm_odd;
    logic [31:0]              writedatam_odd;
    logic                     memwritem_even;
    logic [AW-1:0]            aluoutm_even;
    logic [31:0]              writedatam_even;
    logic [31:0]              readdatam_odd;
    logic [31:0]              readdatam_even;
    logic [31:0]              mem_rdata_odd;
    logic [31:0]              mem_rdata_even;
    logic [AW-1:0]            mem_raddr_odd;
    logic [AW-1:0]            mem_raddr_even;
    logic                     mem_we;
    logic [AW-1:0]            mem_waddr;
    logic [31:0]              mem_wdata;
    logic                     mem_ready;
    logic                     stall_req;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    // Master is the pipeline plus memory environment; slave is the buffer itself.
    modport master (
        output memwritem_odd, aluoutm_odd, writedatam_odd,
        output memwritem_even, aluoutm_even, writedatam_even,
        output mem_rdata_odd, mem_rdata_even, mem_ready,
        input  readdatam_odd, readdatam_even, mem_raddr_odd, mem_raddr_even,
        input  mem_we, mem_waddr, mem_wdata, stall_req, empty, count, overflow
    );

    modport slave (
        input  memwritem_odd, aluoutm_odd, writedatam_odd,
        input  memwritem_even, aluoutm_even, writedatam_even,
        input  mem_rdata_odd, mem_rdata_even, mem_ready,
        output readdatam_odd, readdatam_even, mem_raddr_odd, mem_raddr_even,
        output mem_we, mem_waddr, mem_wdata, stall_req, empty, count, overflow
    );
endinterface

// File: rtl/store_buffer_dual.sv
// Dual-enqueue, single-drain store buffer with program-order load forwarding for the
// ODD/EVEN memory stages of a dual-issue pipeline.
module store_buffer_dual #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input logic                 clk,
    input logic                 reset,
    store_buffer_dual_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_even;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free;
    logic [CW-1:0] n_enq;
    logic          overflow_q;
    logic          acc_odd;
    logic          acc_even;
    logic          drop;
    logic          deq;

    // Free space is sampled before this cycle's drain; ODD wins the last slot.
    assign free      = DEPTH_C - count_q;
    assign acc_odd   = bus.memwritem_odd && (free != '0);
    assign acc_even  = bus.memwritem_even && (free >= (acc_odd ? CW'(2) : CW'(1)));
    assign drop      = (bus.memwritem_odd && !acc_odd) || (bus.memwritem_even && !acc_even);
    assign deq       = (count_q != '0) && bus.mem_ready;
    assign tail_even = tail + PW'(acc_odd);
    assign n_enq     = CW'(acc_odd) + CW'(acc_even);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (acc_odd) begin
                addr_q[tail] <= bus.aluoutm_odd;
                data_q[tail] <= bus.writedatam_odd;
            end
            if (acc_even) begin
                addr_q[tail_even] <= bus.aluoutm_even;
                data_q[tail_even] <= bus.writedatam_even;
            end
            tail    <= tail + PW'(acc_odd) + PW'(acc_even);
            head    <= head + PW'(deq);
            count_q <= count_q + n_enq - CW'(deq);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    logic          hit_odd;
    logic          hit_even;
    logic [31:0]   fwd_odd;
    logic [31:0]   fwd_even;
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        hit_odd  = 1'b0;
        hit_even = 1'b0;
        fwd_odd  = '0;
        fwd_even = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (CW'(i) < count_q) begin
                if (addr_q[fwd_idx][AW-1:2] == bus.aluoutm_odd[AW-1:2]) begin
                    hit_odd = 1'b1;
                    fwd_odd = data_q[fwd_idx];
                end
                if (addr_q[fwd_idx][AW-1:2] == bus.aluoutm_even[AW-1:2]) begin
                    hit_even = 1'b1;
                    fwd_even = data_q[fwd_idx];
                end
            end
        end
    end

    // The same-cycle ODD store is older than the EVEN load, so it beats the buffer.
    always_comb begin
        if (hit_odd) begin
            bus.readdatam_odd = fwd_odd;
        end else begin
            bus.readdatam_odd = bus.mem_rdata_odd;
        end
        if (bus.memwritem_odd && (bus.aluoutm_odd[AW-1:2] == bus.aluoutm_even[AW-1:2])) begin
            bus.readdatam_even = bus.writedatam_odd;
        end else if (hit_even) begin
            bus.readdatam_even = fwd_even;
        end else begin
            bus.readdatam_even = bus.mem_rdata_even;
        end
    end

    assign bus.mem_raddr_odd  = bus.aluoutm_odd;
    assign bus.mem_raddr_even = bus.aluoutm_even;
    assign bus.mem_we         = (count_q != '0);
    assign bus.mem_waddr      = addr_q[head];
    assign bus.mem_wdata      = data_q[head];
    assign bus.stall_req      = (free < CW'(2));
    assign bus.empty          = (count_q == '0);
    assign bus.count          = count_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_store_buffer_dual.sv
// Directed, table-driven bench for store_buffer_dual with hand-written sequences for
// asynchronous reset and pointer wrap-around.
module tb_store_buffer_dual;
    localparam logic [31:0] M_O = 32'h1111_0000;
    localparam logic [31:0] M_E = 32'h2222_0000;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    store_buffer_dual_if #(.DEPTH(8), .AW(32)) bus ();

    store_buffer_dual #(.DEPTH(8), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we_o;
        logic [31:0] a_o;
        logic [31:0] d_o;
        logic        we_e;
        logic [31:0] a_e;
        logic [31:0] d_e;
        logic        rdy;
        logic [31:0] mem_o;
        logic [31:0] mem_e;
        logic [3:0]  e_count;
        logic        e_we;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdo;
        logic [31:0] e_rde;
        logic        e_stall;
        logic        e_empty;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.memwritem_odd   = v.we_o;
        bus.aluoutm_odd     = v.a_o;
        bus.writedatam_odd  = v.d_o;
        bus.memwritem_even  = v.we_e;
        bus.aluoutm_even    = v.a_e;
        bus.writedatam_even = v.d_e;
        bus.mem_ready       = v.rdy;
        bus.mem_rdata_odd   = v.mem_o;
        bus.mem_rdata_even  = v.mem_e;
    endtask

    task automatic check_vec(input int n, input vec_t v);
        checkOutput($sformatf("v%0d.count", n), 32'(bus.count), 32'(v.e_count));
        checkOutput($sformatf("v%0d.mem_we", n), 32'(bus.mem_we), 32'(v.e_we));
        checkOutput($sformatf("v%0d.mem_waddr", n), bus.mem_waddr, v.e_waddr);
        checkOutput($sformatf("v%0d.mem_wdata", n), bus.mem_wdata, v.e_wdata);
        checkOutput($sformatf("v%0d.readdatam_odd", n), bus.readdatam_odd, v.e_rdo);
        checkOutput($sformatf("v%0d.readdatam_even", n), bus.readdatam_even, v.e_rde);
        checkOutput($sformatf("v%0d.stall_req", n), 32'(bus.stall_req), 32'(v.e_stall));
        checkOutput($sformatf("v%0d.empty", n), 32'(bus.empty), 32'(v.e_empty));
        checkOutput($sformatf("v%0d.overflow", n), 32'(bus.overflow), 32'(v.e_ovf));
        checkOutput($sformatf("v%0d.mem_raddr_odd", n), bus.mem_raddr_odd, v.a_o);
        checkOutput($sformatf("v%0d.mem_raddr_even", n), bus.mem_raddr_even, v.a_e);
    endtask

    task automatic drive_idle(input logic rdy);
        vec_t v;
        v = '{0, 32'h0, 32'h0, 0, 32'h4, 32'h0, rdy, M_O, M_E,
              4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
        applyStimulus(v);
    endtask

    // Pulse reset between clock edges and check state while it is still asserted.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        checkOutput({tag, ".count"}, 32'(bus.count), 32'd0);
        checkOutput({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, ".mem_waddr"}, bus.mem_waddr, 32'h0);
        checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        checkOutput({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
        checkOutput({tag, ".empty"}, 32'(bus.empty), 32'd1);
        checkOutput({tag, ".stall_req"}, 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   writes;
        int   waited;

        n_compared   = 0;
        n_mismatched = 0;

        //            we_o a_o    d_o            we_e a_e    d_e            rdy mem_o mem_e           cnt we waddr  wdata          rdo           rde            stl emp ovf
        vecs[0]  = '{1, 32'h10, 32'hAAAA0001, 1, 32'h14, 32'hBBBB0002, 1, M_O, M_E,           4'd0, 0, 32'h0,  32'h0,         M_O,          M_E,           0, 1, 0};
        vecs[1]  = '{0, 32'h14, 32'h0,        0, 32'h10, 32'h0,        1, M_O, M_E,           4'd2, 1, 32'h10, 32'hAAAA0001, 32'hBBBB0002, 32'hAAAA0001, 0, 0, 0};
        vecs[2]  = '{0, 32'h10, 32'h0,        0, 32'h14, 32'h0,        1, M_O, M_E,           4'd1, 1, 32'h14, 32'hBBBB0002, M_O,          32'hBBBB0002, 0, 0, 0};
        vecs[3]  = '{0, 32'h10, 32'h0,        0, 32'h40, 32'h0,        1, M_O, 32'hDEADBEEF,  4'd0, 0, 32'h0,  32'h0,         M_O,          32'hDEADBEEF, 0, 1, 0};
        vecs[4]  = '{1, 32'h20, 32'h1,        1, 32'h20, 32'h2,        0, M_O, M_E,           4'd0, 0, 32'h0,  32'h0,         M_O,          32'h1,         0, 1, 0};
        vecs[5]  = '{1, 32'h20, 32'h3,        0, 32'h20, 32'h0,        0, M_O, M_E,           4'd2, 1, 32'h20, 32'h1,         32'h2,        32'h3,         0, 0, 0};
        vecs[6]  = '{1, 32'h30, 32'h30,       1, 32'h34, 32'h34,       0, M_O, M_E,           4'd3, 1, 32'h20, 32'h1,         M_O,          M_E,           0, 0, 0};
        vecs[7]  = '{1, 32'h38, 32'h38,       0, 32'h20, 32'h0,        0, M_O, M_E,           4'd5, 1, 32'h20, 32'h1,         M_O,          32'h3,         0, 0, 0};
        vecs[8]  = '{1, 32'h50, 32'h50,       1, 32'h54, 32'h54,       0, M_O, M_E,           4'd6, 1, 32'h20, 32'h1,         M_O,          M_E,           0, 0, 0};
        vecs[9]  = '{1, 32'h60, 32'h60,       1, 32'h54, 32'h64,       0, M_O, M_E,           4'd8, 1, 32'h20, 32'h1,         M_O,          32'h54,        1, 0, 0};
        vecs[10] = '{0, 32'h50, 32'h0,        0, 32'h38, 32'h0,        1, M_O, M_E,           4'd8, 1, 32'h20, 32'h1,         32'h50,       32'h38,        1, 0, 1};
        vecs[11] = '{0, 32'h20, 32'h0,        0, 32'h60, 32'h0,        1, M_O, M_E,           4'd7, 1, 32'h20, 32'h2,         32'h3,        M_E,           1, 0, 1};
        vecs[12] = '{0, 32'h34, 32'h0,        0, 32'h10, 32'h0,        0, M_O, M_E,           4'd6, 1, 32'h20, 32'h3,         32'h34,       M_E,           0, 0, 1};

        reset = 1'b1;
        drive_idle(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #4;
            check_vec(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        $display("[TB] reset clears a full, overflowed buffer");
        drive_idle(1'b0);
        reset_pulse("rst_full");

        $display("[TB] reset mid-stream");
        v = '{1, 32'h70, 32'h7, 1, 32'h74, 32'h8, 0, M_O, M_E, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
        applyStimulus(v);
        @(posedge clk);
        #1;
        v = '{1, 32'h78, 32'h9, 0, 32'h70, 32'h0, 0, M_O, M_E, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
        applyStimulus(v);
        @(posedge clk);
        #1;
        drive_idle(1'b0);
        bus.aluoutm_odd = 32'h70;
        #1;
        checkOutput("mid.count_before", 32'(bus.count), 32'd3);
        checkOutput("mid.fwd_before", bus.readdatam_odd, 32'h7);
        reset_pulse("rst_mid");
        bus.aluoutm_odd = 32'h70;
        #1;
        checkOutput("mid.fwd_discarded", bus.readdatam_odd, M_O);

        $display("[TB] wrap-around stream");
        writes = 0;
        for (int k = 0; k < 20; k++) begin
            drive_idle(1'b1);
            bus.memwritem_odd  = 1'b1;
            bus.aluoutm_odd    = 32'h100 + 32'(4 * k);
            bus.writedatam_odd = 32'hC0DE0000 + 32'(k);
            bus.aluoutm_even   = (k == 0) ? 32'h400 : 32'h100 + 32'(4 * (k - 1));
            #4;
            if (k == 0) begin
                checkOutput("wrap.we_first", 32'(bus.mem_we), 32'd0);
            end else begin
                checkOutput($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd1);
                checkOutput($sformatf("wrap%0d.mem_we", k), 32'(bus.mem_we), 32'd1);
                checkOutput($sformatf("wrap%0d.waddr", k), bus.mem_waddr, 32'h100 + 32'(4 * (k - 1)));
                checkOutput($sformatf("wrap%0d.wdata", k), bus.mem_wdata, 32'hC0DE0000 + 32'(k - 1));
                checkOutput($sformatf("wrap%0d.fwd_even", k), bus.readdatam_even, 32'hC0DE0000 + 32'(k - 1));
                writes++;
            end
            @(posedge clk);
            #1;
        end
        drive_idle(1'b1);
        #4;
        checkOutput("wrap.last_waddr", bus.mem_waddr, 32'h100 + 32'(4 * 19));
        checkOutput("wrap.last_wdata", bus.mem_wdata, 32'hC0DE0000 + 32'd19);
        waited = 0;
        while (bus.mem_we && waited < 10) begin
            writes++;
            @(posedge clk);
            #4;
            waited++;
        end
        checkOutput("wrap.drained", 32'(bus.empty), 32'd1);
        checkOutput("wrap.write_total", 32'(writes), 32'd20);
        checkOutput("wrap.overflow", 32'(bus.overflow), 32'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
